// File: rtl/ex_stage.sv
// ex_stage: execute stage. Selects operands, runs the ALU, resolves branches and jumps, and registers EX/MEM.
// Optional shift-add multiplier (aluop 9) with upstream stall, enabled by defining EX_MUL_EN.
module ex_stage #(
   parameter int DATA_W = 33,
   parameter int RD_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_ctrl_regwrt,
   input  logic              in_ctrl_memtoreg,
   input  logic              in_ctrl_memrd,
   input  logic              in_ctrl_memwrt,
   input  logic              in_ctrl_branch,
   input  logic              in_ctrl_btype,
   input  logic              in_ctrl_jump,
   input  logic [3:0]        in_ctrl_aluop,
   input  logic              in_ctrl_alusrc1,
   input  logic              in_ctrl_alusrc0,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_rs,
   input  logic [DATA_W-1:0] in_rt,
   input  logic [DATA_W-1:0] in_x,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_rt,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_ctrl_regwrt,
   output logic              out_ctrl_memtoreg,
   output logic              out_ctrl_memrd,
   output logic              out_ctrl_memwrt,
   output logic              out_flush,
   output logic [DATA_W-1:0] out_target
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_PASSB = 4'd7;
   localparam logic [3:0] OP_NEG   = 4'd8;
   localparam logic [6:0] SH_LIM   = 7'(DATA_W);

   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] target;
   logic [5:0]        shamt;
   logic              shift_ovf;
   logic              br_taken;
   logic              taken;
   logic              ld_valid;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [DATA_W-1:0] cap_rt;
   logic [RD_W-1:0]   cap_rd;
   logic [3:0]        cap_ctrl;

   // Operand selection and single-cycle ALU; MUL is handled by the iterative unit
   always_comb begin
      op_a      = in_ctrl_alusrc1 ? in_pc : in_rs;
      op_b      = in_ctrl_alusrc0 ? in_x : in_rt;
      shamt     = op_b[5:0];
      shift_ovf = ({1'b0, shamt} >= SH_LIM);
      case (in_ctrl_aluop)
         OP_ADD:   alu_result = op_a + op_b;
         OP_SUB:   alu_result = op_a - op_b;
         OP_AND:   alu_result = op_a & op_b;
         OP_OR:    alu_result = op_a | op_b;
         OP_XOR:   alu_result = op_a ^ op_b;
         OP_SLL:   alu_result = shift_ovf ? '0 : (op_a << shamt);
         OP_SRL:   alu_result = shift_ovf ? '0 : (op_a >> shamt);
         OP_PASSB: alu_result = op_b;
         OP_NEG:   alu_result = '0 - op_a;
         default:  alu_result = '0;
      endcase
   end

   // Branch/jump resolution; a flush in EX/MEM turns the current input into a bubble
   always_comb begin
      br_taken = in_ctrl_branch & (in_ctrl_btype ? alu_result[DATA_W-1] : (alu_result == '0));
      taken    = in_ctrl_jump | br_taken;
      if (in_ctrl_jump) begin
         target = in_rs;
      end else begin
         target = in_pc + in_x;
      end
      ld_valid = in_valid & ~out_flush;
   end

`ifdef EX_MUL_EN
   localparam int          CW       = $clog2(DATA_W);
   localparam logic [3:0]  OP_MUL   = 4'd9;
   localparam logic [CW-1:0] LAST   = CW'(DATA_W - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [DATA_W-1:0] mul_acc;
   logic [DATA_W-1:0] mul_sum;
   logic              mul_start;
   logic              mul_last;

   // Stall is low in the last BUSY cycle so upstream advances as the product loads
   always_comb begin
      mul_start   = (state == IDLE) & ld_valid & (in_ctrl_aluop == OP_MUL);
      mul_last    = (state == BUSY) & (count == LAST);
      mul_sum     = mul_acc + (mul_b[0] ? mul_a : '0);
      out_stall   = mul_start | ((state == BUSY) & ~mul_last);
      mul_done    = mul_last;
      mul_product = mul_sum;
   end

   // Multiplier FSM: one shift-add step per BUSY cycle, operands and controls captured at accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         mul_acc  <= '0;
         cap_rt   <= '0;
         cap_rd   <= '0;
         cap_ctrl <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (mul_start) begin
                  state    <= BUSY;
                  count    <= '0;
                  mul_a    <= op_a;
                  mul_b    <= op_b;
                  mul_acc  <= '0;
                  cap_rt   <= in_rt;
                  cap_rd   <= in_rd;
                  cap_ctrl <= {in_ctrl_regwrt, in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt};
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               mul_acc <= mul_sum;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               count   <= count + CW'(1);
               if (mul_last) begin
                  state <= IDLE;
               end else begin
                  state <= BUSY;
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end
`else
   assign out_stall   = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
   assign cap_rt      = '0;
   assign cap_rd      = '0;
   assign cap_ctrl    = 4'b0000;
`endif

   // EX/MEM register: product on MUL completion, bubble while stalled, else the ALU path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid         <= 1'b0;
         out_result        <= '0;
         out_rt            <= '0;
         out_rd            <= '0;
         out_ctrl_regwrt   <= 1'b0;
         out_ctrl_memtoreg <= 1'b0;
         out_ctrl_memrd    <= 1'b0;
         out_ctrl_memwrt   <= 1'b0;
         out_flush         <= 1'b0;
         out_target        <= '0;
      end else if (mul_done) begin
         out_valid         <= 1'b1;
         out_result        <= mul_product;
         out_rt            <= cap_rt;
         out_rd            <= cap_rd;
         out_ctrl_regwrt   <= cap_ctrl[3];
         out_ctrl_memtoreg <= cap_ctrl[2];
         out_ctrl_memrd    <= cap_ctrl[1];
         out_ctrl_memwrt   <= cap_ctrl[0];
         out_flush         <= 1'b0;
      end else if (out_stall) begin
         out_valid         <= 1'b0;
         out_ctrl_regwrt   <= 1'b0;
         out_ctrl_memtoreg <= 1'b0;
         out_ctrl_memrd    <= 1'b0;
         out_ctrl_memwrt   <= 1'b0;
         out_flush         <= 1'b0;
      end else begin
         out_valid         <= ld_valid;
         out_result        <= alu_result;
         out_rt            <= in_rt;
         out_rd            <= in_rd;
         out_ctrl_regwrt   <= ld_valid & in_ctrl_regwrt;
         out_ctrl_memtoreg <= ld_valid & in_ctrl_memtoreg;
         out_ctrl_memrd    <= ld_valid & in_ctrl_memrd;
         out_ctrl_memwrt   <= ld_valid & in_ctrl_memwrt;
         out_flush         <= ld_valid & taken;
         out_target        <= target;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table for single-cycle ops plus directed multi-cycle sequences.
module tb_ex_stage;
   localparam int DW = 33;
   localparam int RW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ctrl_regwrt, in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt;
   logic          in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_alusrc1, in_ctrl_alusrc0;
   logic [3:0]    in_ctrl_aluop;
   logic [DW-1:0] in_pc, in_rs, in_rt, in_x;
   logic [RW-1:0] in_rd;
   logic          out_stall, out_valid, out_flush;
   logic          out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt;
   logic [DW-1:0] out_result, out_rt, out_target;
   logic [RW-1:0] out_rd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(DW), .RD_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_memtoreg(in_ctrl_memtoreg),
      .in_ctrl_memrd(in_ctrl_memrd), .in_ctrl_memwrt(in_ctrl_memwrt),
      .in_ctrl_branch(in_ctrl_branch), .in_ctrl_btype(in_ctrl_btype), .in_ctrl_jump(in_ctrl_jump),
      .in_ctrl_aluop(in_ctrl_aluop), .in_ctrl_alusrc1(in_ctrl_alusrc1), .in_ctrl_alusrc0(in_ctrl_alusrc0),
      .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_x(in_x), .in_rd(in_rd),
      .out_stall(out_stall), .out_valid(out_valid), .out_result(out_result), .out_rt(out_rt),
      .out_rd(out_rd), .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memtoreg(out_ctrl_memtoreg),
      .out_ctrl_memrd(out_ctrl_memrd), .out_ctrl_memwrt(out_ctrl_memwrt),
      .out_flush(out_flush), .out_target(out_target)
   );

   typedef struct {
      string         name;
      logic          valid;
      logic [3:0]    op;
      logic          s1, s0;
      logic [DW-1:0] pc, rs, rt, x;
      logic          br, bt, jp;
      logic          e_valid;
      logic [DW-1:0] e_res;
      logic          e_flush;
      logic [DW-1:0] e_tgt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string n, input logic [3:0] op, input logic s1, input logic s0,
                               input logic [DW-1:0] pc, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                               input logic [DW-1:0] x, input logic br, input logic bt, input logic jp,
                               input logic [DW-1:0] res, input logic fl, input logic [DW-1:0] tgt);
      vec_t v;
      v.name = n; v.valid = 1'b1; v.op = op; v.s1 = s1; v.s0 = s0;
      v.pc = pc; v.rs = rs; v.rt = rt; v.x = x; v.br = br; v.bt = bt; v.jp = jp;
      v.e_valid = 1'b1; v.e_res = res; v.e_flush = fl; v.e_tgt = tgt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_in();
      in_valid = 1'b0; in_ctrl_regwrt = 1'b0; in_ctrl_memtoreg = 1'b0; in_ctrl_memrd = 1'b0;
      in_ctrl_memwrt = 1'b0; in_ctrl_branch = 1'b0; in_ctrl_btype = 1'b0; in_ctrl_jump = 1'b0;
      in_ctrl_aluop = 4'd0; in_ctrl_alusrc1 = 1'b0; in_ctrl_alusrc0 = 1'b0;
      in_pc = '0; in_rs = '0; in_rt = '0; in_x = '0; in_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
      clear_in();
      in_valid = 1'b1; in_ctrl_regwrt = 1'b1; in_ctrl_aluop = op; in_rs = rs; in_rt = rt;
   endtask

   task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] exp);
      int  n;
      int  bad;
      logic done;
      n = 0; bad = 0; done = 1'b0;
      set_op(4'd9, a, b);
      in_rd = 6'd21;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!out_stall) begin
            done = 1'b1;
            break;
         end
         n++;
         if (out_valid) bad++;
         step();
         in_ctrl_aluop = 4'd0; in_rs = DW'($urandom); in_rt = DW'($urandom); in_rd = 6'd7;
      end
      chk("mul_stall_ended", done, 1'b1);
      chk("mul_stall_cycles", n, 33);
      chk("mul_bubbles", bad, 0);
      step();
      chk("mul_valid", out_valid, 1'b1);
      chk("mul_result", out_result, exp);
      chk("mul_rd", out_rd, 6'd21);
      chk("mul_regwrt", out_ctrl_regwrt, 1'b1);
      chk("mul_stall_after", out_stall, 1'b0);
      clear_in();
      step();
   endtask

   initial begin
      vecs.push_back(mk("add",     4'd0, 1'b0, 1'b0, 33'd0, 33'd5, 33'd3, 33'd0, 1'b0, 1'b0, 1'b0, 33'd8, 1'b0, 33'd0));
      vecs.push_back(mk("sub",     4'd1, 1'b0, 1'b0, 33'd0, 33'd5, 33'd3, 33'd0, 1'b0, 1'b0, 1'b0, 33'd2, 1'b0, 33'd0));
      vecs.push_back(mk("sub_neg", 4'd1, 1'b0, 1'b0, 33'd0, 33'd3, 33'd5, 33'd0, 1'b0, 1'b0, 1'b0, 33'h1_FFFF_FFFE, 1'b0, 33'd0));
      vecs.push_back(mk("and",     4'd2, 1'b0, 1'b0, 33'd0, 33'hF0, 33'h3C, 33'd0, 1'b0, 1'b0, 1'b0, 33'h30, 1'b0, 33'd0));
      vecs.push_back(mk("or",      4'd3, 1'b0, 1'b0, 33'd0, 33'hF0, 33'h3C, 33'd0, 1'b0, 1'b0, 1'b0, 33'hFC, 1'b0, 33'd0));
      vecs.push_back(mk("xor",     4'd4, 1'b0, 1'b0, 33'd0, 33'hF0, 33'h3C, 33'd0, 1'b0, 1'b0, 1'b0, 33'hCC, 1'b0, 33'd0));
      vecs.push_back(mk("sll32",   4'd5, 1'b0, 1'b0, 33'd0, 33'd1, 33'd32, 33'd0, 1'b0, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, 33'd0));
      vecs.push_back(mk("sll33",   4'd5, 1'b0, 1'b0, 33'd0, 33'd1, 33'd33, 33'd0, 1'b0, 1'b0, 1'b0, 33'd0, 1'b0, 33'd0));
      vecs.push_back(mk("srl32",   4'd6, 1'b0, 1'b0, 33'd0, 33'h1_0000_0000, 33'd32, 33'd0, 1'b0, 1'b0, 1'b0, 33'd1, 1'b0, 33'd0));
      vecs.push_back(mk("srl63",   4'd6, 1'b0, 1'b0, 33'd0, 33'h1_FFFF_FFFF, 33'd63, 33'd0, 1'b0, 1'b0, 1'b0, 33'd0, 1'b0, 33'd0));
      vecs.push_back(mk("srl_b67", 4'd6, 1'b0, 1'b0, 33'd0, 33'h80, 33'd67, 33'd0, 1'b0, 1'b0, 1'b0, 33'h10, 1'b0, 33'd0));
      vecs.push_back(mk("passb_x", 4'd7, 1'b0, 1'b1, 33'd0, 33'd9, 33'd9, 33'h77, 1'b0, 1'b0, 1'b0, 33'h77, 1'b0, 33'd0));
      vecs.push_back(mk("neg",     4'd8, 1'b0, 1'b0, 33'd0, 33'd1, 33'd0, 33'd0, 1'b0, 1'b0, 1'b0, 33'h1_FFFF_FFFF, 1'b0, 33'd0));
      vecs.push_back(mk("add_pcx", 4'd0, 1'b1, 1'b1, 33'h100, 33'd9, 33'd9, 33'd4, 1'b0, 1'b0, 1'b0, 33'h104, 1'b0, 33'd0));
      vecs.push_back(mk("add_wrap", 4'd0, 1'b0, 1'b0, 33'd0, 33'h1_FFFF_FFFF, 33'd1, 33'd0, 1'b0, 1'b0, 1'b0, 33'd0, 1'b0, 33'd0));
      vecs.push_back(mk("op12",    4'd12, 1'b0, 1'b0, 33'd0, 33'd5, 33'd3, 33'd0, 1'b0, 1'b0, 1'b0, 33'd0, 1'b0, 33'd0));
`ifndef EX_MUL_EN
      vecs.push_back(mk("op9_off", 4'd9, 1'b0, 1'b0, 33'd0, 33'd6, 33'd7, 33'd0, 1'b0, 1'b0, 1'b0, 33'd0, 1'b0, 33'd0));
`endif
      vecs.push_back(mk("bubble",  4'd0, 1'b0, 1'b0, 33'd0, 33'd5, 33'd3, 33'd0, 1'b0, 1'b0, 1'b0, 33'd8, 1'b0, 33'd0));
      vecs[vecs.size()-1].valid = 1'b0;
      vecs[vecs.size()-1].e_valid = 1'b0;
      vecs.push_back(mk("blt_take", 4'd1, 1'b0, 1'b0, 33'h40, 33'd3, 33'd5, 33'h10, 1'b1, 1'b1, 1'b0, 33'h1_FFFF_FFFE, 1'b1, 33'h50));
      vecs.push_back(mk("blt_not", 4'd1, 1'b0, 1'b0, 33'h40, 33'd5, 33'd3, 33'h10, 1'b1, 1'b1, 1'b0, 33'd2, 1'b0, 33'd0));
      vecs.push_back(mk("beq_not", 4'd1, 1'b0, 1'b0, 33'h40, 33'd5, 33'd3, 33'h10, 1'b1, 1'b0, 1'b0, 33'd2, 1'b0, 33'd0));
      vecs.push_back(mk("jmp_br",  4'd1, 1'b0, 1'b0, 33'h40, 33'h200, 33'h200, 33'h10, 1'b1, 1'b0, 1'b1, 33'd0, 1'b1, 33'h200));

      // Reset held two cycles with a valid instruction present
      clear_in();
      rst_n = 1'b0;
      set_op(4'd0, 33'd5, 33'd3);
      in_ctrl_memwrt = 1'b1; in_ctrl_memrd = 1'b1; in_ctrl_memtoreg = 1'b1; in_ctrl_jump = 1'b1; in_rd = 6'd9;
      step();
      step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_result", out_result, 33'd0);
      chk("rst_rt", out_rt, 33'd0);
      chk("rst_rd", out_rd, 6'd0);
      chk("rst_ctrl", {out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt}, 4'd0);
      chk("rst_flush", out_flush, 1'b0);
      chk("rst_target", out_target, 33'd0);
      chk("rst_stall", out_stall, 1'b0);
      rst_n = 1'b1;
      clear_in();
      step();

      // Vector table: one instruction, then a bubble to clear any flush
      foreach (vecs[i]) begin
         clear_in();
         in_valid = vecs[i].valid; in_ctrl_aluop = vecs[i].op;
         in_ctrl_alusrc1 = vecs[i].s1; in_ctrl_alusrc0 = vecs[i].s0;
         in_pc = vecs[i].pc; in_rs = vecs[i].rs; in_rt = vecs[i].rt; in_x = vecs[i].x;
         in_ctrl_branch = vecs[i].br; in_ctrl_btype = vecs[i].bt; in_ctrl_jump = vecs[i].jp;
         in_ctrl_regwrt = 1'b1; in_ctrl_memwrt = 1'b1; in_rd = RW'(i);
         step();
         chk({vecs[i].name, "_valid"}, out_valid, vecs[i].e_valid);
         chk({vecs[i].name, "_regwrt"}, out_ctrl_regwrt, vecs[i].e_valid);
         chk({vecs[i].name, "_memwrt"}, out_ctrl_memwrt, vecs[i].e_valid);
         chk({vecs[i].name, "_flush"}, out_flush, vecs[i].e_flush);
         if (vecs[i].e_valid) begin
            chk({vecs[i].name, "_result"}, out_result, vecs[i].e_res);
            chk({vecs[i].name, "_rt"}, out_rt, vecs[i].rt);
            chk({vecs[i].name, "_rd"}, out_rd, RW'(i));
         end
         if (vecs[i].e_flush) chk({vecs[i].name, "_target"}, out_target, vecs[i].e_tgt);
         clear_in();
         step();
      end

      // ADD then SUB back to back
      set_op(4'd0, 33'd5, 33'd3);
      step();
      chk("b2b_add", out_result, 33'd8);
      chk("b2b_add_valid", out_valid, 1'b1);
      set_op(4'd1, 33'd5, 33'd3);
      step();
      chk("b2b_sub", out_result, 33'd2);
      chk("b2b_sub_valid", out_valid, 1'b1);

      // Taken BEQ, then a valid (MUL) instruction squashed during the flush cycle
      set_op(4'd1, 33'd7, 33'd7);
      in_ctrl_branch = 1'b1; in_pc = 33'h40; in_x = 33'h10;
      step();
      chk("beq_flush", out_flush, 1'b1);
      chk("beq_target", out_target, 33'h50);
      set_op(4'd9, 33'd1, 33'd1);
      #1;
      chk("squash_nostall", out_stall, 1'b0);
      step();
      clear_in();
      #1;
      chk("squash_valid", out_valid, 1'b0);
      chk("squash_flush", out_flush, 1'b0);
      chk("squash_stall", out_stall, 1'b0);
      step();

      // Jump, then a second jump in the flush cycle that must never flush
      set_op(4'd0, 33'h123, 33'd0);
      in_ctrl_jump = 1'b1;
      step();
      chk("jmp_flush", out_flush, 1'b1);
      chk("jmp_target", out_target, 33'h123);
      set_op(4'd0, 33'h456, 33'd0);
      in_ctrl_jump = 1'b1;
      step();
      chk("jmp2_flush", out_flush, 1'b0);
      chk("jmp2_valid", out_valid, 1'b0);
      clear_in();
      step();
      chk("jmp2_later_flush", out_flush, 1'b0);

`ifdef EX_MUL_EN
      do_mul(33'd6, 33'd7, 33'd42);
      do_mul(33'h1_0000_0001, 33'd3, 33'h1_0000_0003);

      // Reset while BUSY with count=10
      set_op(4'd9, 33'd6, 33'd7);
      step();
      clear_in();
      repeat (10) step();
      chk("mid_busy_stall", out_stall, 1'b1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_stall", out_stall, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      rst_n = 1'b1;
`else
      set_op(4'd0, 33'd9, 33'd9);
      step();
      rst_n = 1'b0;
      clear_in();
      step();
      chk("mid_rst_stall", out_stall, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      rst_n = 1'b1;
`endif
      set_op(4'd0, 33'd1, 33'd1);
      step();
      chk("post_rst_add", out_result, 33'd2);
      chk("post_rst_valid", out_valid, 1'b1);
      clear_in();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
